// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c write master between two
// configuration sequencers (port 0 = HDMI TX queue, port 1 = audio codec).
// A granted request is copied into the master command registers, the master
// is started with a one-cycle pulse, and its busy flag is tracked to
// completion. A busy flag that never rises is reported as an error after
// BUSY_TIMEOUT cycles.
module i2c_arbiter #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_0,
    input  logic [6:0] address_0,
    input  logic [7:0] data0_0,
    input  logic [7:0] data1_0,
    input  logic       req_1,
    input  logic [6:0] address_1,
    input  logic [7:0] data0_1,
    input  logic [7:0] data1_1,
    output logic       grant_0,
    output logic       grant_1,
    output logic       done_0,
    output logic       done_1,
    output logic       err_0,
    output logic       err_1,
    output logic       i2c_start,
    output logic [6:0] i2c_address,
    output logic [7:0] i2c_data_0,
    output logic [7:0] i2c_data_1,
    input  logic       i2c_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RELEASE
    } state_t;

    // Counter value at which a still-low busy is declared a timeout.
    localparam logic [7:0] CNT_LIMIT = 8'(BUSY_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_0_q, grant_0_d;
    logic       grant_1_q, grant_1_d;
    logic       done_0_q, done_0_d;
    logic       done_1_q, done_1_d;
    logic       err_0_q, err_0_d;
    logic       err_1_q, err_1_d;
    logic       start_q, start_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] dat0_q, dat0_d;
    logic [7:0] dat1_q, dat1_d;

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        grant_0_d    = grant_0_q;
        grant_1_d    = grant_1_q;
        done_0_d     = 1'b0;
        done_1_d     = 1'b0;
        err_0_d      = 1'b0;
        err_1_d      = 1'b0;
        start_d      = 1'b0;
        addr_d       = addr_q;
        dat0_d       = dat0_q;
        dat1_d       = dat1_q;

        case (state_q)
            IDLE: begin
                // Port 0 wins when alone or when port 1 was served last.
                if (req_0 && (!req_1 || last_grant_q)) begin
                    grant_0_d    = 1'b1;
                    last_grant_d = 1'b0;
                    addr_d       = address_0;
                    dat0_d       = data0_0;
                    dat1_d       = data1_0;
                    state_d      = START;
                end else if (req_1) begin
                    grant_1_d    = 1'b1;
                    last_grant_d = 1'b1;
                    addr_d       = address_1;
                    dat0_d       = data0_1;
                    dat1_d       = data1_1;
                    state_d      = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = 8'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy has priority over the timeout on the limit cycle.
                if (i2c_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    err_0_d = grant_0_q;
                    err_1_d = grant_1_q;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                // The master bounds its own transfer, so no timeout here.
                if (!i2c_busy) begin
                    done_0_d = grant_0_q;
                    done_1_d = grant_1_q;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                // One dead cycle so a requester's stale req is never resampled.
                grant_0_d = 1'b0;
                grant_1_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                grant_0_d = 1'b0;
                grant_1_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            grant_0_q    <= 1'b0;
            grant_1_q    <= 1'b0;
            done_0_q     <= 1'b0;
            done_1_q     <= 1'b0;
            err_0_q      <= 1'b0;
            err_1_q      <= 1'b0;
            start_q      <= 1'b0;
            addr_q       <= 7'd0;
            dat0_q       <= 8'd0;
            dat1_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            grant_0_q    <= grant_0_d;
            grant_1_q    <= grant_1_d;
            done_0_q     <= done_0_d;
            done_1_q     <= done_1_d;
            err_0_q      <= err_0_d;
            err_1_q      <= err_1_d;
            start_q      <= start_d;
            addr_q       <= addr_d;
            dat0_q       <= dat0_d;
            dat1_q       <= dat1_d;
        end
    end

    assign grant_0     = grant_0_q;
    assign grant_1     = grant_1_q;
    assign done_0      = done_0_q;
    assign done_1      = done_1_q;
    assign err_0       = err_0_q;
    assign err_1       = err_1_q;
    assign i2c_start   = start_q;
    assign i2c_address = addr_q;
    assign i2c_data_0  = dat0_q;
    assign i2c_data_1  = dat1_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: single transfer, tie/alternation,
// busy timeout, timeout boundary, payload stability and mid-transfer reset.
module tb_i2c_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_0, req_1;
    logic [6:0] address_0, address_1;
    logic [7:0] data0_0, data1_0, data0_1, data1_1;
    logic       grant_0, grant_1, done_0, done_1, err_0, err_1;
    logic       i2c_start;
    logic [6:0] i2c_address;
    logic [7:0] i2c_data_0, i2c_data_1;
    logic       i2c_busy;

    int n_asserts = 0;
    int n_fail    = 0;

    i2c_arbiter #(.BUSY_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_0       (req_0),
        .address_0   (address_0),
        .data0_0     (data0_0),
        .data1_0     (data1_0),
        .req_1       (req_1),
        .address_1   (address_1),
        .data0_1     (data0_1),
        .data1_1     (data1_1),
        .grant_0     (grant_0),
        .grant_1     (grant_1),
        .done_0      (done_0),
        .done_1      (done_1),
        .err_0       (err_0),
        .err_1       (err_1),
        .i2c_start   (i2c_start),
        .i2c_address (i2c_address),
        .i2c_data_0  (i2c_data_0),
        .i2c_data_1  (i2c_data_1),
        .i2c_busy    (i2c_busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) req_0 = v;
        else        req_1 = v;
    endtask

    // One full transaction for port p, starting with FSM in IDLE and reqs set.
    // d: cycles busy stays low after the start pulse; hold: busy-high cycles.
    task automatic transfer(input int p, input logic [6:0] ea, input logic [7:0] e0,
                            input logic [7:0] e1, input int d, input int hold,
                            input bit timeout, input bit scramble, input bit reraise);
        logic [1:0] gexp;
        gexp = (p == 0) ? 2'b01 : 2'b10;
        tick();
        chk($sformatf("grant p%0d", p), {grant_1, grant_0}, gexp);
        chk($sformatf("payload p%0d", p), {i2c_address, i2c_data_0, i2c_data_1}, {ea, e0, e1});
        chk("start before", i2c_start, 1'b0);
        tick();
        chk("start pulse", i2c_start, 1'b1);
        if (timeout) begin
            for (int i = 1; i < 16; i++) begin
                tick();
                chk($sformatf("no early err t%0d", i), {err_1, err_0, i2c_start}, 3'b000);
            end
            tick();
            chk($sformatf("timeout err p%0d", p), {err_1, err_0}, gexp);
            chk("timeout no done", {done_1, done_0}, 2'b00);
        end else begin
            for (int i = 0; i < d; i++) tick();
            i2c_busy = 1'b1;
            tick();
            chk("no err on busy", {err_1, err_0}, 2'b00);
            if (scramble) begin
                address_0 = 7'h1A;
                address_1 = 7'h1A;
            end
            for (int i = 0; i < hold; i++) tick();
            chk("payload held", {i2c_address, i2c_data_0, i2c_data_1}, {ea, e0, e1});
            chk("no done while busy", {done_1, done_0}, 2'b00);
            i2c_busy = 1'b0;
            tick();
            chk($sformatf("done p%0d", p), {done_1, done_0}, gexp);
            chk("err stays low", {err_1, err_0}, 2'b00);
            chk("grant during done", {grant_1, grant_0}, gexp);
        end
        set_req(p, 1'b0);
        tick();
        chk($sformatf("release p%0d", p), {grant_1, grant_0, done_1, done_0, err_1, err_0}, 6'd0);
        if (reraise) set_req(p, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; i2c_busy = 1'b0;
        address_0 = 7'h39; data0_0 = 8'h41; data1_0 = 8'h10;
        address_1 = 7'h2C; data0_1 = 8'hA5; data1_1 = 8'h5A;
        tick();
        tick();
        chk("reset outputs", {grant_1, grant_0, done_1, done_0, err_1, err_0, i2c_start,
                              i2c_address, i2c_data_0, i2c_data_1}, 0);
        rst = 1'b0;

        // Single request with a payload change during the transfer.
        req_0 = 1'b1;
        transfer(0, 7'h39, 8'h41, 8'h10, 2, 40, 1'b0, 1'b1, 1'b0);
        tick();
        chk("idle no grant", {grant_1, grant_0}, 2'b00);
        chk("addr kept after done", i2c_address, 7'h39);

        // Tie after reset, then strict alternation with both held.
        address_0 = 7'h39; address_1 = 7'h2C;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1;
        transfer(0, 7'h39, 8'h41, 8'h10, 1, 5, 1'b0, 1'b0, 1'b1);
        transfer(1, 7'h2C, 8'hA5, 8'h5A, 0, 3, 1'b0, 1'b0, 1'b1);
        transfer(0, 7'h39, 8'h41, 8'h10, 2, 4, 1'b0, 1'b0, 1'b1);
        transfer(1, 7'h2C, 8'hA5, 8'h5A, 1, 2, 1'b0, 1'b0, 1'b0);
        req_0 = 1'b0;
        tick();
        tick();

        // Busy never rises: timeout on port 1.
        req_1 = 1'b1;
        transfer(1, 7'h2C, 8'hA5, 8'h5A, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("idle after timeout", {grant_1, grant_0, i2c_start}, 3'b000);

        // Busy rises exactly on the limit cycle: busy wins.
        req_1 = 1'b1;
        transfer(1, 7'h2C, 8'hA5, 8'h5A, 15, 6, 1'b0, 1'b0, 1'b0);

        // Busy already high at start is taken as an ack immediately.
        req_0 = 1'b1;
        transfer(0, 7'h39, 8'h41, 8'h10, 0, 3, 1'b0, 1'b0, 1'b0);

        // Reset during WAIT_DONE, then tie again favours port 0.
        req_1 = 1'b1;
        tick();
        chk("grant p1 pre-reset", {grant_1, grant_0}, 2'b10);
        tick();
        i2c_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid reset outputs", {grant_1, grant_0, done_1, done_0, err_1, err_0, i2c_start,
                                  i2c_address}, 0);
        rst = 1'b0;
        i2c_busy = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1;
        transfer(0, 7'h39, 8'h41, 8'h10, 1, 2, 1'b0, 1'b0, 1'b0);
        req_1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
